// File: rtl/ccff_chain_loader_pkg.sv
// rtl/ccff_chain_loader_pkg.sv - shared types and sizing helpers for the ccff chain loader
package ccff_loader_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits carried by the final word of a pass; a full word when the chain divides evenly.
    function automatic int last_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// rtl/ccff_chain_loader_if.sv - valid/ready word stream used for config input and readback output
interface ccff_chain_loader_if #(
    parameter int WORD_W = 8
);
    logic [WORD_W-1:0] data;
    logic              valid;
    logic              ready;

    modport master (output data, output valid, input ready);
    modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/ccff_chain_loader_readback_sipo.sv
// rtl/ccff_chain_loader_readback_sipo.sv - collects chain tail bits into zero-padded readback words
module ccff_readback_sipo #(
    parameter int WORD_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 capture,
    input  logic                 flush,
    input  logic                 tail,
    ccff_chain_loader_if.master  m
);
    localparam int IDX_W = $clog2(WORD_W);

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [IDX_W-1:0]  idx;
    logic [WORD_W-1:0] data_q;
    logic              valid_q;

    // Bits land at their final position, so clearing acc per word zero-pads a short last word.
    always_comb begin
        acc_next      = acc;
        acc_next[idx] = tail;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            idx     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (valid_q && m.ready) begin
                valid_q <= 1'b0;
            end
            if (capture) begin
                if (flush) begin
                    data_q  <= acc_next;
                    valid_q <= 1'b1;
                    acc     <= '0;
                    idx     <= '0;
                end else begin
                    acc <= acc_next;
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign m.data  = data_q;
    assign m.valid = valid_q;

endmodule

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - streams config words LSB-first into the scff chain and returns the old contents
module ccff_chain_loader
    import ccff_loader_pkg::*;
#(
    parameter int WORD_W    = 8,
    parameter int CHAIN_LEN = 64,
    parameter int CNT_W     = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    ccff_chain_loader_if.slave  s,
    output logic                ccff_head,
    output logic                ccff_shift_en,
    input  logic                ccff_tail,
    ccff_chain_loader_if.master m,
    output logic                busy,
    output logic                done
);
    localparam int REM_W     = $clog2(WORD_W + 1);
    localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int LAST_BITS = last_bits(CHAIN_LEN, WORD_W);

    localparam logic [CNT_W-1:0] LAST_WORD_IDX = CNT_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0] CHAIN_END     = CNT_W'(CHAIN_LEN);
    localparam logic [REM_W-1:0] FULL_BITS     = REM_W'(WORD_W);
    localparam logic [REM_W-1:0] TAIL_BITS     = REM_W'(LAST_BITS);

    state_t            state_q, state_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [REM_W-1:0]  rem_q, rem_d;
    logic [CNT_W-1:0]  bits_done_q, bits_done_d;
    logic [CNT_W-1:0]  word_idx_q, word_idx_d;
    logic              s_ready_q, s_ready_d;
    logic              head_q, head_d;
    logic              shift_q, shift_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              accept;
    logic              hold_busy;
    logic              last_shift;
    logic [REM_W-1:0]  word_len;

    assign accept     = s.valid && s_ready_q;
    // Readback word still unclaimed after this edge; the next shift must wait.
    assign hold_busy  = m.valid && !m.ready;
    assign last_shift = shift_q && (rem_q == REM_W'(1));
    assign word_len   = (word_idx_q == LAST_WORD_IDX) ? TAIL_BITS : FULL_BITS;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            rem_q       <= '0;
            bits_done_q <= '0;
            word_idx_q  <= '0;
            s_ready_q   <= 1'b0;
            head_q      <= 1'b0;
            shift_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            rem_q       <= rem_d;
            bits_done_q <= bits_done_d;
            word_idx_q  <= word_idx_d;
            s_ready_q   <= s_ready_d;
            head_q      <= head_d;
            shift_q     <= shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        rem_d       = rem_q;
        bits_done_d = bits_done_q;
        word_idx_d  = word_idx_q;
        s_ready_d   = 1'b0;
        head_d      = head_q;
        shift_d     = 1'b0;
        busy_d      = busy_q;
        done_d      = done_q;

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = LOAD;
                    s_ready_d   = 1'b1;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    bits_done_d = '0;
                    word_idx_d  = '0;
                end
            end
            LOAD: begin
                s_ready_d = 1'b1;
                if (accept) begin
                    state_d   = SHIFT;
                    s_ready_d = 1'b0;
                    word_d    = s.data;
                    rem_d     = word_len;
                    head_d    = s.data[0];
                    shift_d   = !hold_busy;
                end
            end
            SHIFT: begin
                if (shift_q) begin
                    word_d      = word_q >> 1;
                    rem_d       = rem_q - 1'b1;
                    bits_done_d = bits_done_q + 1'b1;
                    head_d      = word_q[1];
                    if (rem_q == REM_W'(1)) begin
                        head_d     = 1'b0;
                        word_idx_d = word_idx_q + 1'b1;
                        if ((bits_done_q + CNT_W'(1)) == CHAIN_END) begin
                            state_d = DONE;
                            busy_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            state_d   = LOAD;
                            s_ready_d = 1'b1;
                        end
                    end else begin
                        // Readback only refills at a word boundary, so mid-word shifting never stalls.
                        shift_d = 1'b1;
                    end
                end else begin
                    head_d  = word_q[0];
                    shift_d = !hold_busy;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    ccff_readback_sipo #(
        .WORD_W (WORD_W)
    ) u_readback (
        .clk     (clk),
        .rst     (rst),
        .capture (shift_q),
        .flush   (last_shift),
        .tail    (ccff_tail),
        .m       (m)
    );

    assign s.ready       = s_ready_q;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - directed bench driving a 64-cell and a 12-cell chain loader
module tb_ccff_chain_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] start;
    logic [1:0] s_valid;
    logic [1:0] m_ready;
    logic [7:0] s_data [2];

    wire  [1:0] head, shift_en, busy, done, s_ready, m_valid, tail;
    wire  [7:0] m_data [2];

    ccff_chain_loader_if #(.WORD_W(8)) s0_if ();
    ccff_chain_loader_if #(.WORD_W(8)) m0_if ();
    ccff_chain_loader_if #(.WORD_W(8)) s1_if ();
    ccff_chain_loader_if #(.WORD_W(8)) m1_if ();

    assign s0_if.data  = s_data[0];
    assign s0_if.valid = s_valid[0];
    assign s_ready[0]  = s0_if.ready;
    assign m0_if.ready = m_ready[0];
    assign m_valid[0]  = m0_if.valid;
    assign m_data[0]   = m0_if.data;
    assign s1_if.data  = s_data[1];
    assign s1_if.valid = s_valid[1];
    assign s_ready[1]  = s1_if.ready;
    assign m1_if.ready = m_ready[1];
    assign m_valid[1]  = m1_if.valid;
    assign m_data[1]   = m1_if.data;

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(64), .CNT_W(16)) dut64 (
        .clk (clk), .rst (rst), .start (start[0]), .s (s0_if),
        .ccff_head (head[0]), .ccff_shift_en (shift_en[0]), .ccff_tail (tail[0]),
        .m (m0_if), .busy (busy[0]), .done (done[0])
    );

    ccff_chain_loader #(.WORD_W(8), .CHAIN_LEN(12), .CNT_W(16)) dut12 (
        .clk (clk), .rst (rst), .start (start[1]), .s (s1_if),
        .ccff_head (head[1]), .ccff_shift_en (shift_en[1]), .ccff_tail (tail[1]),
        .m (m1_if), .busy (busy[1]), .done (done[1])
    );

    // Behavioural scff chains: head enters cell 0, tail is the last cell.
    logic [63:0] chain0 = '0;
    logic [11:0] chain1 = '0;
    int          nshift0 = 0;
    int          nshift1 = 0;
    logic [7:0]  rbq0 [$];
    logic [7:0]  rbq1 [$];

    always @(posedge clk) begin
        if (shift_en[0]) begin
            chain0  <= {chain0[62:0], head[0]};
            nshift0 <= nshift0 + 1;
        end
        if (shift_en[1]) begin
            chain1  <= {chain1[10:0], head[1]};
            nshift1 <= nshift1 + 1;
        end
        if (m_valid[0] && m_ready[0]) rbq0.push_back(m_data[0]);
        if (m_valid[1] && m_ready[1]) rbq1.push_back(m_data[1]);
    end

    assign tail = {chain1[11], chain0[63]};

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] tx     [8];
    logic [7:0] exp_rb [8];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    function automatic int shifts(input int u);
        return (u == 0) ? nshift0 : nshift1;
    endfunction

    function automatic int rb_size(input int u);
        return (u == 0) ? rbq0.size() : rbq1.size();
    endfunction

    function automatic logic [7:0] rb_at(input int u, input int i);
        if (u == 0) return (i < rbq0.size()) ? rbq0[i] : 8'hxx;
        return (i < rbq1.size()) ? rbq1[i] : 8'hxx;
    endfunction

    task automatic pulse_start(input int u);
        start[u] = 1'b1;
        tick();
        start[u] = 1'b0;
    endtask

    task automatic send(input int u, input logic [7:0] d, input int gap);
        repeat (gap) tick();
        s_data[u]  = d;
        s_valid[u] = 1'b1;
        for (int k = 0; k < 200; k++) begin
            if (s_ready[u]) break;
            tick();
        end
        chk($sformatf("accept_u%0d", u), s_ready[u], 1'b1);
        tick();
        s_valid[u] = 1'b0;
    endtask

    task automatic wait_done(input int u);
        for (int k = 0; k < 400; k++) begin
            if (done[u]) break;
            tick();
        end
        chk($sformatf("done_u%0d", u), done[u], 1'b1);
    endtask

    task automatic chk_rb(input int u, input int base, input int n, input string tag);
        chk({tag, "_count"}, rb_size(u) - base, n);
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_w%0d", tag, i), rb_at(u, base + i), exp_rb[i]);
    endtask

    task automatic do_pass(input int u, input int n, input int gap, output int base, output int sh);
        base = rb_size(u);
        sh   = shifts(u);
        pulse_start(u);
        for (int i = 0; i < n; i++) send(u, tx[i], gap);
        wait_done(u);
        repeat (2) tick();
    endtask

    initial begin
        int          base, sh, sh2;
        logic [63:0] snap, exp_chain;

        rst = 1'b1; start = '0; s_valid = '0; m_ready = 2'b11;
        s_data[0] = '0; s_data[1] = '0;
        repeat (3) tick();
        chk("rst_s_ready", s_ready, 2'b00);
        chk("rst_shift_en", shift_en, 2'b00);
        chk("rst_head", head, 2'b00);
        chk("rst_m_valid", m_valid, 2'b00);
        chk("rst_busy", busy, 2'b00);
        chk("rst_done", done, 2'b00);
        chk("rst_m_data", m_data[0], 8'h00);
        rst = 1'b0;
        tick();

        // Pass A: zero chain, words 0x01..0x08
        for (int i = 0; i < 8; i++) tx[i] = 8'(i + 1);
        base = rb_size(0); sh = nshift0;
        pulse_start(0);
        chk("a_busy", busy[0], 1'b1);
        chk("a_s_ready", s_ready[0], 1'b1);
        send(0, tx[0], 0);
        chk("a_first_shift", shift_en[0], 1'b1);
        chk("a_first_head", head[0], 1'b1);
        chk("a_s_ready_drop", s_ready[0], 1'b0);
        for (int i = 1; i < 8; i++) send(0, tx[i], 0);
        wait_done(0);
        chk("a_busy_done", busy[0], 1'b0);
        repeat (2) tick();
        chk("a_shifts", nshift0 - sh, 64);
        for (int i = 0; i < 8; i++) exp_rb[i] = 8'h00;
        chk_rb(0, base, 8, "a_rb");

        // Pass B: 0xA5 x8 returns pass A words in order
        for (int i = 0; i < 8; i++) tx[i] = 8'hA5;
        do_pass(0, 8, 0, base, sh);
        chk("b_shifts", nshift0 - sh, 64);
        for (int i = 0; i < 8; i++) exp_rb[i] = 8'(i + 1);
        chk_rb(0, base, 8, "b_rb");
        chk("b_chain", chain0, 64'hA5A5_A5A5_A5A5_A5A5);

        // 12-cell chain: partial final word
        tx[0] = 8'hFF; tx[1] = 8'hFF;
        do_pass(1, 2, 0, base, sh);
        chk("c1_shifts", nshift1 - sh, 12);
        exp_rb[0] = 8'h00; exp_rb[1] = 8'h00;
        chk_rb(1, base, 2, "c1_rb");
        do_pass(1, 2, 0, base, sh);
        exp_rb[0] = 8'hFF; exp_rb[1] = 8'h0F;
        chk_rb(1, base, 2, "c2_rb");
        chk("c2_chain", chain1, 12'hFFF);
        tx[0] = 8'h3C; tx[1] = 8'hA7;
        do_pass(1, 2, 0, base, sh);
        chk("c3_shifts", nshift1 - sh, 12);
        chk_rb(1, base, 2, "c3_rb");
        chk("c3_chain", chain1, 12'h3CE);

        // Backpressure on readback
        m_ready[1] = 1'b0;
        base = rb_size(1); sh = nshift1;
        pulse_start(1);
        send(1, 8'h00, 0);
        for (int k = 0; k < 50; k++) begin
            if (m_valid[1]) break;
            tick();
        end
        chk("bp_m_valid", m_valid[1], 1'b1);
        chk("bp_m_data", m_data[1], 8'h3C);
        send(1, 8'h00, 0);
        sh2 = nshift1;
        repeat (5) tick();
        chk("bp_stall_shifts", nshift1 - sh2, 0);
        chk("bp_stall_en", shift_en[1], 1'b0);
        chk("bp_hold_valid", m_valid[1], 1'b1);
        chk("bp_hold_data", m_data[1], 8'h3C);
        m_ready[1] = 1'b1;
        wait_done(1);
        repeat (2) tick();
        chk("bp_shifts", nshift1 - sh, 12);
        exp_rb[0] = 8'h3C; exp_rb[1] = 8'h07;
        chk_rb(1, base, 2, "bp_rb");
        chk("bp_chain", chain1, 12'h000);

        // Reset during bit 3 of word 2
        pulse_start(0);
        send(0, 8'h11, 0);
        send(0, 8'h22, 0);
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_s_ready", s_ready[0], 1'b0);
        chk("mid_rst_shift_en", shift_en[0], 1'b0);
        chk("mid_rst_head", head[0], 1'b0);
        chk("mid_rst_m_valid", m_valid[0], 1'b0);
        chk("mid_rst_busy", busy[0], 1'b0);
        chk("mid_rst_done", done[0], 1'b0);
        chk("mid_rst_m_data", m_data[0], 8'h00);
        sh = nshift0;
        repeat (3) tick();
        rst = 1'b0;
        chk("mid_rst_no_shift", nshift0 - sh, 0);

        // s_valid without start is ignored
        s_data[0] = 8'h55; s_valid[0] = 1'b1;
        repeat (3) tick();
        chk("idle_s_ready", s_ready[0], 1'b0);
        chk("idle_no_shift", nshift0 - sh, 0);
        s_valid[0] = 1'b0;
        tick();

        // Fresh load with start pulsed during SHIFT and 5-cycle valid gaps
        tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h56; tx[3] = 8'h78;
        tx[4] = 8'h9A; tx[5] = 8'hBC; tx[6] = 8'hDE; tx[7] = 8'hF0;
        snap = chain0;
        for (int k = 0; k < 8; k++)
            for (int j = 0; j < 8; j++)
                exp_rb[k][j] = snap[63 - (8 * k + j)];
        for (int i = 0; i < 64; i++) exp_chain[63 - i] = tx[i / 8][i % 8];
        base = rb_size(0); sh = nshift0;
        pulse_start(0);
        send(0, tx[0], 5);
        pulse_start(0);
        chk("f_busy_after_start", busy[0], 1'b1);
        for (int i = 1; i < 8; i++) send(0, tx[i], 5);
        wait_done(0);
        repeat (2) tick();
        chk("f_shifts", nshift0 - sh, 64);
        chk_rb(0, base, 8, "f_rb");
        chk("f_chain", chain0, exp_chain);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Upstream feeder for the scff configuration chain that holds frac_lut4/soft_adder LUT masks.
- Accepts configuration words over a valid/ready stream and shifts them LSB-first into the chain head, one bit per enabled clk.
- Simultaneously captures the bits falling out of the chain tail and returns them as readback words, so previous chain contents can be verified.
- Signals completion after exactly CHAIN_LEN shifts.

Parameters:
- WORD_W, 8: stream word width, in bits; at least 2.
- CHAIN_LEN, 64: number of scff cells in the chain; at least 1.
- CNT_W, 16: width of the bit counter; must satisfy 2^CNT_W > CHAIN_LEN.

Ports:
- clk  in  1  single clock; also clocks the chain scffs.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a load; sampled only in IDLE or DONE.
- s_data  in  WORD_W  configuration word; bit 0 is shifted first.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  loader accepts s_data this cycle.
- ccff_head  out  1  serial bit driven to the chain D input.
- ccff_shift_en  out  1  chain clock enable; the chain shifts on each clk edge where this is 1.
- ccff_tail  in  1  Q of the last chain cell.
- m_data  out  WORD_W  readback word; bit 0 is the first tail bit.
- m_valid  out  1  readback word valid.
- m_ready  in  1  readback consumer ready.
- busy  out  1  high in LOAD or SHIFT.
- done  out  1  high in DONE until the next start.

Behaviour:
- All outputs are registered. On any edge with rst=1: state=IDLE; s_ready, ccff_head, ccff_shift_en, m_valid, busy, done = 0; m_data and counters = 0.
- Reset mid-operation aborts immediately. Chain contents are left partially shifted, with no further shifts.
- IDLE: start=1 -> LOAD; bit counter = 0.
- LOAD: s_ready=1. On s_valid&&s_ready, latch s_data -> SHIFT.
  - s_ready drops the cycle after acceptance.
  - Words are never accepted outside LOAD.
- SHIFT: each cycle with m_valid==0 || m_ready==1:
  - ccff_shift_en=1; ccff_head = current word bit.
  - At that edge, ccff_tail is captured into the readback shift register.
  - Otherwise (m_valid && !m_ready): ccff_shift_en=0 and no bit advances (stall).
- Bits per word: min(WORD_W, CHAIN_LEN - bits_done). The final word may be partial; its unused upper s_data bits are ignored.
- Word exhausted:
  - if bits_done == CHAIN_LEN -> DONE;
  - else -> LOAD.
- Throughput is WORD_W+1 cycles per word with no backpressure. First ccff_shift_en occurs 1 cycle after acceptance.
- Readback:
  - m_valid rises the cycle after WORD_W tail bits are collected, or after the last chain bit.
  - A partial final readback word is zero-padded in the upper bits.
  - m_data/m_valid hold until m_ready.
- DONE: done=1, busy=0, s_ready=0.
  - start -> LOAD, with a new pass and counters cleared.
  - A pending readback word must be drained (m_valid stays high) independent of start.
- start is ignored in LOAD/SHIFT.
- s_valid without start is ignored (s_ready=0).
- Total ccff_shift_en pulses per pass is exactly CHAIN_LEN.
- Word count is ceil(CHAIN_LEN/WORD_W).

Decomposition:
- Package ccff_loader_pkg:
  - state enum {IDLE, LOAD, SHIFT, DONE};
  - function num_words(CHAIN_LEN, WORD_W) = ceil division;
  - function last_bits(CHAIN_LEN, WORD_W) = remainder, or WORD_W if zero.
- Sub-module ccff_readback_sipo: tail bit collector with zero-pad on final flush and an m_valid/m_ready holding register.
- The main module owns the FSM, PISO and counters.

Test Plan:
- Bench: behavioural CHAIN_LEN-cell scff chain model, clocked by clk and gated by ccff_shift_en.
- Zero chain; WORD_W=8, CHAIN_LEN=64; load words 0x01..0x08; m_ready=1 -> 64 shift pulses, done=1, eight readback words of 0x00.
- Second pass with 0xA5 x8 -> readback returns 0x01..0x08 in order; chain then holds all 0xA5.
- CHAIN_LEN=12; load 0xFF, 0xFF -> 12 shifts; second word uses 4 bits; readback words 0x00 then 0x00; third pass readback is 0xFF then 0x0F.
- Backpressure: hold m_ready=0 after the first readback word -> ccff_shift_en stays 0 and m_data is stable; release -> shifting resumes with no lost or duplicated bits.
- Reset asserted mid-SHIFT (bit 3 of word 2) -> next cycle all outputs 0, no shift pulses; a fresh start completes a correct full load.
- start pulsed during SHIFT and s_valid gaps of 5 cycles in LOAD -> start ignored, loader waits in LOAD; total shifts still exactly CHAIN_LEN.
